// File: rtl/mlp_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// mlp_layer_sequencer_if
// Bundles the sequencer's request, neuron-array and result ports.
//   master : the sequencer itself (drives control, activations and result)
//   slave  : the surrounding system (requester, neuron array, consumer)
// Vectors are packed as [element][bit]; element i is vec[i].
// ---------------------------------------------------------------------------
interface mlp_layer_sequencer_if #(
  parameter int N     = 4,
  parameter int M     = 3,
  parameter int WIDTH = 16
) ();

  // Request side
  logic                              start;
  logic signed [N-1:0][WIDTH-1:0]    x_in;
  logic                              busy;

  // Neuron-array side
  logic [$clog2(M)-1:0]              layer_addr;
  logic                              layer_start;
  logic signed [N-1:0][WIDTH-1:0]    act_out;
  logic                              layer_done;
  logic signed [N-1:0][WIDTH-1:0]    y_layer;

  // Result side
  logic                              out_valid;
  logic                              out_ready;
  logic signed [N-1:0][WIDTH-1:0]    result;
  logic                              done;
  logic                              error;

  modport master (
    input  start, x_in, layer_done, y_layer, out_ready,
    output busy, layer_addr, layer_start, act_out, out_valid, result, done, error
  );

  modport slave (
    output start, x_in, layer_done, y_layer, out_ready,
    input  busy, layer_addr, layer_start, act_out, out_valid, result, done, error
  );

endinterface

// File: rtl/mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_layer_sequencer
// Steps a fully-connected network through layers 0..M-1. The input vector is
// latched on start, each layer is kicked with a one-cycle layer_start, and the
// neuron array's outputs replace the activation register when layer_done
// arrives. After the last layer the activation register is offered on a
// valid/ready port; done pulses for one cycle after the handshake.
//
// Optional feature: define LAYER_TIMEOUT_EN to add a per-layer watchdog that
// aborts to IDLE with a one-cycle error pulse when a layer takes TIMEOUT
// WAIT cycles without layer_done. Without it, WAIT waits indefinitely and
// error is constant 0.
//
// All outputs decode registered state only; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module mlp_layer_sequencer #(
  parameter int N       = 4,
  parameter int M       = 3,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mlp_layer_sequencer_if.master bus
);

  localparam int AW = $clog2(M);
  localparam logic [AW-1:0] LAST_LAYER = AW'(M - 1);

  // Elaboration-time parameter sanity checks
  if (M < 2) begin : g_bad_m
    $error("mlp_layer_sequencer: M must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mlp_layer_sequencer: TIMEOUT must be at least 1");
  end

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                     state_q;
  logic [AW-1:0]                  addr_q;
  logic signed [N-1:0][WIDTH-1:0] act_q;
  logic                           done_q;
  logic                           error_q;
  logic                           wd_expire;

`ifdef LAYER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] wd_cnt_q;

  // Watchdog: cleared in RUN so every WAIT entry starts from zero, then
  // counts WAIT cycles; wd_cnt_q == k-1 during the k-th WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_q <= wd_cnt_q + CW'(1);
    end
  end

  // Abort at the end of the TIMEOUT-th WAIT cycle unless the layer finished.
  assign wd_expire = (state_q == S_WAIT) && !bus.layer_done &&
                     (wd_cnt_q == CW'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Main sequencer: state, layer address, activation register and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      // NOTE: act_q is a plain register bank, not a RAM, so it takes a reset
      // value; a reset mid-run must leave act_out/result at zero.
      act_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block so every
      // branch sees the pre-edge values of state_q/addr_q; blocking here
      // would make the increment and the last-layer compare order-dependent.
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            act_q   <= bus.x_in;
            addr_q  <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.layer_done) begin
            act_q <= bus.y_layer;
            if (addr_q == LAST_LAYER) begin
              state_q <= S_OUT;
            end else begin
              addr_q  <= addr_q + AW'(1);
              state_q <= S_RUN;
            end
          end else if (wd_expire) begin
            // act_q and addr_q are deliberately left as they were at abort.
            state_q <= S_IDLE;
            error_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state.
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.layer_start = (state_q == S_RUN);
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.layer_addr  = addr_q;
  assign bus.act_out     = act_q;
  assign bus.result      = act_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Layer-by-layer sequencer for the fully-connected network datapath. It latches an N-element input vector and steps `layer_addr` through layers 0..M-1 of the weight store. For each layer it pulses `layer_start` to the neuron array and captures the array's outputs as the next layer's input. After the last layer it presents the final vector on a valid/ready output port.

## Interface
Parameters:
- `N`, 4: neurons per layer; also the input and output vector length.
- `M`, 3: number of layers; must be ≥2 so `layer_addr` is at least 1 bit.
- `WIDTH`, 16: signed data word width.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with `LAYER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new inference; sampled only in IDLE.
- `x_in`  in  signed [WIDTH-1:0] [N-1:0]  network input vector, latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `layer_addr`  out  [$clog2(M)-1:0]  layer select to the weight store.
- `layer_start`  out  1  one-cycle pulse telling the neuron array to evaluate the current layer.
- `act_out`  out  signed [WIDTH-1:0] [N-1:0]  current layer input vector to the neuron array.
- `layer_done`  in  1  neuron array finished; `y_layer` is valid this cycle.
- `y_layer`  in  signed [WIDTH-1:0] [N-1:0]  neuron array outputs.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  signed [WIDTH-1:0] [N-1:0]  final network output.
- `done`  out  1  one-cycle pulse after the output handshake.
- `error`  out  1  one-cycle pulse on watchdog abort; tied to 0 without `LAYER_TIMEOUT_EN`.

## Operation
- State register: `act_reg[N]`. `act_out` and `result` are both driven directly from `act_reg`.
- States:
  - IDLE: when `start`=1, load `act_reg`←`x_in`, set `layer_addr`←0, go to RUN.
  - RUN: `layer_start`=1 for this cycle, then go to WAIT.
  - WAIT: when `layer_done`=1, load `act_reg`←`y_layer`. If `layer_addr`==M-1, go to OUT; otherwise increment `layer_addr` and go to RUN.
  - OUT: `out_valid`=1. When `out_ready`=1, go to IDLE and set `done`=1 for the next cycle.
- Outputs are Moore-style and registered from state. No combinational path from any input to any output.
- `start` is ignored outside IDLE. `layer_done` is ignored outside WAIT.
- `layer_addr` never exceeds M-1 and does not wrap. It holds its last value in OUT and IDLE until the next accepted `start` resets it to 0.
- `act_reg`/`result` is stable throughout OUT, regardless of `out_ready` stalls.
- Data is passed through unmodified; there is no arithmetic on the data path.

## Timing
- Reset values: state IDLE, `layer_addr`=0, `act_reg`=0, `busy`=0, `layer_start`=0, `out_valid`=0, `done`=0, `error`=0.
- Reset asserted mid-operation aborts immediately to the reset values, with no `done` or `error` pulse.
- Cycle numbering: `start` is sampled high at the end of cycle 0.
  - Cycle 1: RUN, `layer_start`=1, `busy`=1.
  - If the neuron array asserts `layer_done` L≥1 cycles after `layer_start`, each layer takes L+1 cycles.
  - `out_valid` first rises in cycle 1+M·(L+1).
  - `done` is high in the cycle after the `out_valid`∧`out_ready` edge; the block is in IDLE during that cycle.
- A `start` during the `done` cycle is accepted (back-to-back operation).
- If `layer_done` is already high in the first WAIT cycle, it is captured at that edge (L=1).

## Configuration
- `LAYER_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `layer_done`, the FSM goes to IDLE, pulses `error` for one cycle, and does not assert `done`.
  - `act_reg` and `layer_addr` keep their values at abort.
- `LAYER_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely; `error`=0 constantly.

## Test plan
- Reset values: assert `rst_n`=0 mid-WAIT → all outputs match the reset list on the same cycle; `busy`=0.
- Basic run: N=4, M=3, `x_in`={1,2,3,4}, neuron model returns `y`=`act_out`+1 with L=4, `out_ready`=1 → `layer_addr` goes 0,1,2; `layer_start` pulses at cycles 1, 6, 11; `out_valid` at cycle 16 with `result`={4,5,6,7}; `done` at cycle 17.
- Backpressure: same run with `out_ready`=0 for 5 cycles → `out_valid` held 6 cycles, `result` unchanged, single `done` pulse.
- Ignored events: `start` pulsed during WAIT and `layer_done` pulsed in RUN/IDLE → no state or `layer_addr` change; sequence timing identical to the basic run.
- Back-to-back: `start` high in the `done` cycle with new `x_in`={10,0,0,0} → next `layer_start` one cycle later, `layer_addr`=0.
- Timeout (macro on, `TIMEOUT`=8): neuron model never asserts `layer_done` → `error` pulses once after 8 WAIT cycles, FSM is in IDLE, no `done`; a subsequent normal run completes correctly.
